// File: rtl/mem_arbiter_2x1_pkg.sv
// Shared constants for the two-requester memory arbiter: state encoding and hold limit.
package mem_arbiter_2x1_pkg;

    localparam int MAX_HOLD_DEFAULT = 4;
    localparam int DATA_W           = 32;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        OWN0 = 2'b01,
        OWN1 = 2'b10
    } arb_state_e;

    function automatic arb_state_e own_state(input logic idx);
        return idx ? OWN1 : OWN0;
    endfunction

endpackage

// File: rtl/mux_2x1.sv
// Plain 2:1 multiplexer used for address and write-data steering.
module mux_2x1 #(
    parameter int W = 32
) (
    input  logic [W-1:0] d0,
    input  logic [W-1:0] d1,
    input  logic         sel,
    output logic [W-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mem_arbiter_2x1.sv
// Two-requester memory port arbiter with registered grants and a bounded hold
// so one requester cannot starve the other while both keep requesting.
module mem_arbiter_2x1
    import mem_arbiter_2x1_pkg::*;
#(
    parameter int MAX_HOLD = MAX_HOLD_DEFAULT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic [DATA_W-1:0] addr0,
    input  logic [DATA_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    input  logic              mem_ready,
    output logic              gnt0,
    output logic              gnt1,
    output logic              sel,
    output logic              mem_valid,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              done0,
    output logic              done1
);

    localparam int HW = $clog2(MAX_HOLD + 1);
    localparam logic [HW-1:0] HOLD_MAX  = HW'(MAX_HOLD);
    localparam logic [HW-1:0] HOLD_LAST = HW'(MAX_HOLD - 1);

    arb_state_e    state_q, state_d;
    logic          sel_q, sel_d;
    logic          last_owner_q, last_owner_d;
    logic [HW-1:0] hold_cnt_q, hold_cnt_d;

    logic own_idx;
    logic own_req;
    logic other_req;
    logic own_done;

    assign gnt0      = (state_q == OWN0);
    assign gnt1      = (state_q == OWN1);
    assign sel       = sel_q;
    assign mem_valid = (gnt0 & req0) | (gnt1 & req1);
    assign mem_we    = sel_q ? we1 : we0;
    assign done0     = gnt0 & mem_valid & mem_ready;
    assign done1     = gnt1 & mem_valid & mem_ready;

    mux_2x1 #(.W(DATA_W)) u_addr_mux (
        .d0  (addr0),
        .d1  (addr1),
        .sel (sel_q),
        .y   (mem_addr)
    );

    mux_2x1 #(.W(DATA_W)) u_wdata_mux (
        .d0  (wdata0),
        .d1  (wdata1),
        .sel (sel_q),
        .y   (mem_wdata)
    );

    assign own_idx   = (state_q == OWN1);
    assign own_req   = own_idx ? req1 : req0;
    assign other_req = own_idx ? req0 : req1;
    assign own_done  = done0 | done1;

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d      = state_q;
        sel_d        = sel_q;
        last_owner_d = last_owner_q;
        hold_cnt_d   = hold_cnt_q;

        unique case (state_q)
            IDLE: begin
                hold_cnt_d = '0;
                // On a tie the requester that did not own last goes first.
                if (req0 && (!req1 || last_owner_q)) begin
                    state_d = OWN0;
                    sel_d   = 1'b0;
                end else if (req1) begin
                    state_d = OWN1;
                    sel_d   = 1'b1;
                end
            end
            OWN0, OWN1: begin
                if (!own_req) begin
                    last_owner_d = own_idx;
                    hold_cnt_d   = '0;
                    if (other_req) begin
                        state_d = own_state(!own_idx);
                        sel_d   = !own_idx;
                    end else begin
                        state_d = IDLE;
                    end
                end else if (own_done) begin
                    // >= rather than == so a saturated count still yields to a new waiter.
                    if (other_req && hold_cnt_q >= HOLD_LAST) begin
                        state_d      = own_state(!own_idx);
                        sel_d        = !own_idx;
                        last_owner_d = own_idx;
                        hold_cnt_d   = '0;
                    end else if (hold_cnt_q != HOLD_MAX) begin
                        hold_cnt_d = hold_cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (!rst_n) begin
            state_q      <= IDLE;
            sel_q        <= 1'b0;
            last_owner_q <= 1'b1;
            hold_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            sel_q        <= sel_d;
            last_owner_q <= last_owner_d;
            hold_cnt_q   <= hold_cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter_2x1.sv
// Directed checks of the arbiter followed by a short protocol-compliant random run.
module tb_mem_arbiter_2x1;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0, req1, we0, we1, mem_ready;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, sel, mem_valid, mem_we, done0, done1;
    logic [31:0] mem_addr, mem_wdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_arbiter_2x1 #(.MAX_HOLD(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .mem_ready (mem_ready),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .sel       (sel),
        .mem_valid (mem_valid),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .done0     (done0),
        .done1     (done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Inputs change 2 time units after each rising edge; outputs are read 1 unit later.
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    logic r0, r1, prev_stall, prev_g0, prev_g1;
    int   wait0, wait1;

    initial begin
        rst_n = 1'b0; req0 = 0; req1 = 0; we0 = 0; we1 = 0; mem_ready = 0;
        addr0 = 32'h0000_0100; addr1 = 32'h0000_0200;
        wdata0 = 32'h1111_1111; wdata1 = 32'h2222_2222;
        tick(); tick();
        settle();
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_sel", sel, 0);
        check("rst_valid", mem_valid, 0);
        rst_n = 1'b1;

        // Single requester streaming reads: granted after one cycle, done every cycle.
        req0 = 1; mem_ready = 1;
        settle();
        check("single_lat_gnt0", gnt0, 0);
        tick(); settle();
        check("single_gnt0", gnt0, 1);
        check("single_addr", mem_addr, 32'h100);
        for (int i = 0; i < 6; i++) begin
            check("single_done0", done0, 1);
            check("single_gnt1", gnt1, 0);
            tick(); settle();
        end
        req0 = 0;
        tick(); settle();
        check("single_release", gnt0, 0);

        // Fresh reset restores requester 0 as first tie winner.
        rst_n = 0; tick(); rst_n = 1;
        req0 = 1; req1 = 1; mem_ready = 1;
        tick(); settle();
        check("tie_gnt0", gnt0, 1);
        for (int i = 0; i < 4; i++) begin
            check("hold_done0", done0, 1);
            check("hold_no_gnt1", gnt1, 0);
            tick(); settle();
        end
        check("hold_switch_gnt1", gnt1, 1);
        check("hold_switch_sel", sel, 1);
        check("hold_switch_addr", mem_addr, 32'h200);
        check("hold_switch_done1", done1, 1);

        // Memory stalls with requester 0 waiting: owner 1 must keep the port untouched.
        mem_ready = 0;
        for (int i = 0; i < 10; i++) begin
            settle();
            check("stall_gnt1", gnt1, 1);
            check("stall_gnt0", gnt0, 0);
            check("stall_valid", mem_valid, 1);
            check("stall_addr", mem_addr, 32'h200);
            check("stall_done1", done1, 0);
            tick();
        end

        // Reset mid-transaction aborts without a done; requester 0 wins the next tie.
        rst_n = 0;
        tick(); settle();
        check("abort_gnt0", gnt0, 0);
        check("abort_gnt1", gnt1, 0);
        check("abort_valid", mem_valid, 0);
        check("abort_done1", done1, 0);
        check("abort_sel", sel, 0);
        rst_n = 1;
        tick(); settle();
        check("post_rst_gnt0", gnt0, 1);

        // Single write, then both requesters idle.
        req1 = 0; we0 = 1; wdata0 = 32'hDEAD_BEEF; mem_ready = 1;
        settle();
        check("wr_we", mem_we, 1);
        check("wr_wdata", mem_wdata, 32'hDEAD_BEEF);
        check("wr_done0", done0, 1);
        tick();
        req0 = 0; we0 = 0;
        tick(); settle();
        check("wr_idle_gnt0", gnt0, 0);
        check("wr_idle_sel", sel, 0);
        check("wr_idle_valid", mem_valid, 0);

        // Dropped request without done releases the grant; sel holds in IDLE.
        req1 = 1; mem_ready = 0;
        tick(); settle();
        check("err_gnt1", gnt1, 1);
        req1 = 0;
        settle();
        check("err_no_done1", done1, 0);
        tick(); settle();
        check("err_release", gnt1, 0);
        check("err_sel_hold", sel, 1);

        // Requester 1 owned last, so requester 0 wins this tie.
        req0 = 1; req1 = 1;
        tick(); settle();
        check("alt_tie_gnt0", gnt0, 1);
        check("alt_tie_sel", sel, 0);

        // Random run with requesters that hold req until done.
        r0 = 1; r1 = 1; prev_stall = 0; prev_g0 = 1; prev_g1 = 0; wait0 = 0; wait1 = 0;
        for (int c = 0; c < 2000; c++) begin
            mem_ready = 1'($urandom_range(0, 1));
            settle();
            check("rnd_onehot", {31'd0, gnt0 & gnt1}, 0);
            if (prev_stall) begin
                check("rnd_stall_g0", gnt0, prev_g0);
                check("rnd_stall_g1", gnt1, prev_g1);
            end
            if (gnt0) wait0 = 0;
            if (gnt1) wait1 = 0;
            if (done1 && r0 && !gnt0) wait0++;
            if (done0 && r1 && !gnt1) wait1++;
            check("rnd_wait0", {31'd0, wait0 > 4}, 0);
            check("rnd_wait1", {31'd0, wait1 > 4}, 0);
            prev_stall = mem_valid & !mem_ready;
            prev_g0 = gnt0;
            prev_g1 = gnt1;
            if (r0 && done0) r0 = 1'($urandom_range(0, 1));
            else if (!r0)    r0 = 1'($urandom_range(0, 1));
            if (r1 && done1) r1 = 1'($urandom_range(0, 1));
            else if (!r1)    r1 = 1'($urandom_range(0, 1));
            if (!r0) wait0 = 0;
            if (!r1) wait1 = 0;
            tick();
            req0 = r0;
            req1 = r1;
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
